// File: rtl/hazard_forward_unit.sv
// Operand forwarding select and load/branch hazard stall engine for the 5-stage pipeline.
// Combinational controls come from current inputs and state; the state and the stall counter are registered.
module hazard_forward_unit #(
  parameter int unsigned REG_W     = 5,
  parameter int unsigned NSRC      = 2,
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic [NSRC*REG_W-1:0]   id_src,
  input  logic [NSRC-1:0]         id_src_vld,
  input  logic                    id_is_branch,
  input  logic [NSRC*REG_W-1:0]   ex_src,
  input  logic [REG_W-1:0]        ex_dst,
  input  logic                    ex_reg_write,
  input  logic                    ex_mem_read,
  input  logic [REG_W-1:0]        mem_dst,
  input  logic                    mem_reg_write,
  input  logic                    mem_mem_read,
  input  logic [REG_W-1:0]        wb_dst,
  input  logic                    wb_reg_write,
  input  logic [REG_W-1:0]        wb2_dst,
  input  logic                    wb2_reg_write,
  output logic [2*NSRC-1:0]       fwd_sel,
  output logic                    stall,
  output logic                    idex_flush,
  output logic [CNT_W-1:0]        stall_cycles
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t state, state_nxt;
  logic   h_lu, h_ba, h_bml, h_bl, hazard;
  logic   id_hit_ex, id_hit_mem;

  // Register 0 is hardwired zero and never produces a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b,
                                     input logic             we);
    return we && (a == b) && (a != '0);
  endfunction

  // Per-operand forwarding select; the youngest producer wins.
  always_comb begin
    fwd_sel = '0;
    if (!rst) begin
      for (int unsigned k = 0; k < NSRC; k++) begin
        if (reg_match(ex_src[k*REG_W +: REG_W], mem_dst, mem_reg_write))
          fwd_sel[2*k +: 2] = 2'b01;
        else if (reg_match(ex_src[k*REG_W +: REG_W], wb_dst, wb_reg_write))
          fwd_sel[2*k +: 2] = 2'b10;
        else if ((WB_BYPASS != 0) && reg_match(ex_src[k*REG_W +: REG_W], wb2_dst, wb2_reg_write))
          fwd_sel[2*k +: 2] = 2'b11;
      end
    end
  end

  // Dependencies of the valid ID operands on the EX and MEM producers.
  always_comb begin
    id_hit_ex  = 1'b0;
    id_hit_mem = 1'b0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (id_src_vld[k] && reg_match(id_src[k*REG_W +: REG_W], ex_dst, ex_reg_write))
        id_hit_ex = 1'b1;
      if (id_src_vld[k] && reg_match(id_src[k*REG_W +: REG_W], mem_dst, mem_reg_write))
        id_hit_mem = 1'b1;
    end
  end

  assign h_lu   = ex_mem_read && id_hit_ex;
  assign h_ba   = id_is_branch && !ex_mem_read && id_hit_ex;
  assign h_bml  = id_is_branch && mem_mem_read && id_hit_mem;
  assign h_bl   = id_is_branch && h_lu;
  assign hazard = h_lu || h_ba || h_bml;

  // Stall controls and next state; freeze holds the state in place.
  always_comb begin
    stall      = 1'b0;
    idex_flush = 1'b0;
    state_nxt  = state;
    if (rst) begin
      state_nxt = RUN;
    end else if (freeze) begin
      stall = 1'b1;
    end else begin
      case (state)
        RUN: begin
          stall      = hazard;
          idex_flush = hazard;
          state_nxt  = h_bl ? HOLD : RUN;
        end
        HOLD: begin
          stall      = 1'b1;
          idex_flush = 1'b1;
          state_nxt  = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // idex_flush is already low while frozen, so the counter holds then too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      if (idex_flush && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
